// File: rtl/ppcm_writer_nexys3.sv
// Parallel PCM word writer: two 16-bit word-program cycles per 32-bit write,
// with status polling, error clear and return to read-array mode.
module ppcm_writer_nexys3 #(
  parameter int CLK_FREQ  = 100,
  parameter int ADDR_BITS = 24,
  parameter int MAX_POLL  = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cs,
  input  logic [ADDR_BITS-1:2]   addr,
  input  logic [31:0]            din,
  output logic                   busy,
  output logic                   ack,
  output logic                   err,
  output logic [7:0]             status,
  output logic                   pcm_ce_n,
  output logic                   pcm_rst_n,
  output logic                   pcm_oe_n,
  output logic                   pcm_we_n,
  output logic [ADDR_BITS-1:1]   pcm_addr,
  input  logic [15:0]            pcm_din,
  output logic [15:0]            pcm_dout
);

  localparam int C_INIT = 1 + CLK_FREQ * 100000 / 1000;
  localparam int C_WP   = 1 + CLK_FREQ * 50 / 1000;
  localparam int C_WPH  = 1 + CLK_FREQ * 30 / 1000;
  localparam int C_RD   = 1 + CLK_FREQ * 115 / 1000;
  localparam int C_MAX  = (C_INIT > C_RD + C_WPH) ? C_INIT : C_RD + C_WPH;
  localparam int CW     = $clog2(C_MAX + 1);
  localparam int PW     = $clog2(MAX_POLL + 1);

  typedef logic [CW-1:0] cnt_t;
  typedef logic [PW-1:0] poll_t;

  localparam cnt_t  INIT_END  = cnt_t'(C_INIT - 1);
  localparam cnt_t  WR_ACT    = cnt_t'(C_WP);
  localparam cnt_t  WR_END    = cnt_t'(C_WP + C_WPH - 1);
  localparam cnt_t  RD_ACT    = cnt_t'(C_RD);
  localparam cnt_t  RD_LAST   = cnt_t'(C_RD - 1);
  localparam cnt_t  RD_END    = cnt_t'(C_RD + C_WPH - 1);
  localparam poll_t POLL_LAST = poll_t'(MAX_POLL - 1);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_CMD, S_DATA,
    S_POLL, S_CLR, S_RA, S_DONE
  } state_t;

  state_t                 state_q, state_d;
  cnt_t                   cnt_q, cnt_d;
  poll_t                  poll_q, poll_d;
  logic                   half_q, half_d;
  logic                   err_q, err_d;
  logic                   ack_q, ack_d;
  logic [7:0]             status_q, status_d;
  logic [ADDR_BITS-1:2]   addr_q, addr_d;
  logic [31:0]            din_q, din_d;
  logic                   ce_n_q, ce_n_d;
  logic                   oe_n_q, oe_n_d;
  logic                   we_n_q, we_n_d;
  logic [15:0]            dout_q, dout_d;
  logic                   rst_n_q;
  logic                   st_bad;
  logic                   unused_hi;

  assign unused_hi = ^pcm_din[15:8];
  assign st_bad    = status_q[4] | status_q[3] | status_q[1];

  function automatic logic is_wr(input state_t s);
    return (s == S_CMD) || (s == S_DATA) ||
           (s == S_CLR) || (s == S_RA);
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    poll_d   = poll_q;
    half_d   = half_q;
    err_d    = err_q;
    ack_d    = 1'b0;
    status_d = status_q;
    addr_d   = addr_q;
    din_d    = din_q;
    unique case (state_q)
      S_INIT: begin
        if (cnt_q == INIT_END) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_IDLE: begin
        cnt_d = '0;
        if (cs) begin
          addr_d  = addr;
          din_d   = din;
          err_d   = 1'b0;
          half_d  = 1'b0;
          poll_d  = '0;
          state_d = S_CMD;
        end
      end
      S_CMD, S_DATA, S_CLR, S_RA: begin
        if (cnt_q == WR_END) begin
          cnt_d = '0;
          if (state_q == S_CMD)  state_d = S_DATA;
          if (state_q == S_DATA) state_d = S_POLL;
          if (state_q == S_CLR)  state_d = S_RA;
          if (state_q == S_RA)   state_d = S_DONE;
        end
      end
      S_POLL: begin
        if (cnt_q == RD_LAST) status_d = pcm_din[7:0];
        if (cnt_q == RD_END) begin
          cnt_d = '0;
          if (!status_q[7]) begin
            if (poll_q == POLL_LAST) begin
              err_d   = 1'b1;
              state_d = S_CLR;
            end else begin
              poll_d = poll_q + 1'b1;
            end
          end else if (st_bad) begin
            err_d   = 1'b1;
            state_d = S_CLR;
          end else if (!half_q) begin
            half_d  = 1'b1;
            poll_d  = '0;
            state_d = S_CMD;
          end else begin
            state_d = S_RA;
          end
        end
      end
      S_DONE: begin
        ack_d   = 1'b1;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_INIT;
      end
    endcase

    // Strobes and data are derived from the next state so the registered
    // pins line up exactly with the state/counter they belong to.
    ce_n_d = 1'b1;
    oe_n_d = 1'b1;
    we_n_d = 1'b1;
    dout_d = dout_q;
    if (is_wr(state_d)) begin
      if (cnt_d < WR_ACT) begin
        ce_n_d = 1'b0;
        we_n_d = 1'b0;
      end
      unique case (state_d)
        S_CMD:   dout_d = 16'h0040;
        S_DATA:  dout_d = half_d ? din_d[31:16] : din_d[15:0];
        S_CLR:   dout_d = 16'h0050;
        default: dout_d = 16'h00FF;
      endcase
    end
    if (state_d == S_POLL && cnt_d < RD_ACT) begin
      ce_n_d = 1'b0;
      oe_n_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    rst_n_q <= ~rst;
    if (rst) begin
      state_q  <= S_INIT;
      cnt_q    <= '0;
      poll_q   <= '0;
      half_q   <= 1'b0;
      err_q    <= 1'b0;
      ack_q    <= 1'b0;
      status_q <= 8'h00;
      addr_q   <= '0;
      din_q    <= '0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      dout_q   <= 16'h0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      poll_q   <= poll_d;
      half_q   <= half_d;
      err_q    <= err_d;
      ack_q    <= ack_d;
      status_q <= status_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      dout_q   <= dout_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign ack       = ack_q;
  assign err       = err_q;
  assign status    = status_q;
  assign pcm_ce_n  = ce_n_q;
  assign pcm_oe_n  = oe_n_q;
  assign pcm_we_n  = we_n_q;
  assign pcm_rst_n = rst_n_q;
  assign pcm_addr  = {addr_q, half_q};
  assign pcm_dout  = dout_q;

endmodule

// File: doc/ppcm_writer_nexys3.md
PPCM_WRITER_NEXYS3 -- requirements
Module: ppcm_writer_nexys3

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100, main clock frequency in MHz.
REQ-002 SHALL have parameter ADDR_BITS, default 24, PCM byte-address width.
REQ-003 SHALL have parameter MAX_POLL, default 4096, status polls per half-word before timeout.
REQ-004 SHALL have port clk, input, 1, main clock.
REQ-005 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-006 SHALL have port cs, input, 1, write request, sampled only in S_IDLE.
REQ-007 SHALL have port addr, input, [ADDR_BITS-1:2], 32-bit word address.
REQ-008 SHALL have port din, input, 32, write data.
REQ-009 SHALL have port busy, output, 1, high in every state except S_IDLE.
REQ-010 SHALL have port ack, output, 1, single-cycle completion pulse.
REQ-011 SHALL have port err, output, 1, failure flag, valid with ack.
REQ-012 SHALL have port status, output, 8, last sampled PCM status register.
REQ-013 SHALL have PCM ports pcm_ce_n, pcm_rst_n, pcm_oe_n, pcm_we_n (outputs, 1 each, active-low), pcm_addr (output, [ADDR_BITS-1:1]), pcm_din (input, 16), pcm_dout (output, 16).

Function
REQ-014 SHALL derive counts as 1 + CLK_FREQ*DELAY/1000 (integer) from DELAY_INIT=100000, DELAY_WP=50, DELAY_WPH=30 and DELAY_RD=115 ns, giving INIT=10001, WP=6, WPH=4 and RD=12 at 100 MHz.
REQ-015 SHALL register pcm_rst_n <= ~rst on every clock.
REQ-016 SHALL use states S_INIT, S_IDLE, S_CMD, S_DATA, S_POLL, S_CLR, S_RA and S_DONE.
REQ-017 SHALL count COUNT_INIT cycles in S_INIT, then enter S_IDLE.
REQ-018 SHALL, in S_IDLE with cs=1, latch addr and din, clear err, set half=0, and enter S_CMD.
REQ-019 SHALL perform each write cycle as WP cycles of ce_n=we_n=0 with addr/dout stable, then WPH cycles of ce_n=we_n=1 with addr/dout held.
REQ-020 SHALL, in S_CMD, write 0x0040 to pcm_addr={addr,half}, then enter S_DATA.
REQ-021 SHALL, in S_DATA, write din[15:0] (half=0) or din[31:16] (half=1) to the same address, then enter S_POLL.
REQ-022 SHALL, in S_POLL, hold ce_n=oe_n=0 and we_n=1 for RD cycles, sample pcm_din[7:0] into status on the last cycle, then hold ce_n=oe_n=1 for WPH cycles.
REQ-023 SHALL, when status[7]=0, repeat S_POLL, incrementing a poll counter.
REQ-024 SHALL, when status[7]=1 and status[4], [3] and [1] are all 0, either set half=1 and go to S_CMD (half=0), or go to S_RA (half=1).
REQ-025 SHALL, when status[7]=1 and any of status[4], [3] or [1] is 1, set err=1, skip the remaining half, and enter S_CLR.
REQ-026 SHALL, when the poll counter reaches MAX_POLL with status[7]=0, set err=1 and enter S_CLR.
REQ-027 SHALL, in S_CLR, write 0x0050, then enter S_RA.
REQ-028 SHALL, in S_RA, write 0x00FF, then enter S_DONE.
REQ-029 SHALL, in S_DONE, pulse ack=1 for exactly one cycle, hold err until the next accepted request, and return to S_IDLE.
REQ-030 SHALL, outside active phases, hold pcm_ce_n, pcm_oe_n and pcm_we_n at 1, and never assert pcm_oe_n and pcm_we_n low together.
REQ-031 SHALL, on a clean write with one poll per half, assert ack 1+2*(2*(WP+WPH)+(RD+WPH))+(WP+WPH) = 83 cycles after cs is sampled at defaults.
REQ-032 SHALL ignore cs while busy; a new request needs cs high in S_IDLE.

Reset
REQ-033 SHALL, on rst, enter S_INIT with all counters cleared.
REQ-034 SHALL, on rst, set busy=1 (S_INIT), ack=0, err=0, status=0x00, pcm_ce_n=pcm_oe_n=pcm_we_n=1, pcm_addr=0, pcm_dout=0.
REQ-035 SHALL, on rst mid-operation, abort the operation without ack, drive pcm_rst_n=0 next cycle, and restart S_INIT.

Verification
REQ-036 SHALL verify power-up: release rst -> busy stays 1 for 10001 cycles, then busy=0 and every pcm strobe is 1.
REQ-037 SHALL verify a clean write: addr=0x000010, din=0xBEEF1234, PCM model status=0x80 -> bus writes 0x0040/0x1234 @0x000020, 0x0040/0xBEEF @0x000021, 0x00FF, then ack 83 cycles after cs with err=0.
REQ-038 SHALL verify slow ready: status reads 0x00 three times, then 0x80 -> three extra 16-cycle polls per half, then ack with err=0.
REQ-039 SHALL verify a program error: low-half status=0x90 -> writes 0x0050 then 0x00FF, high half never programmed, ack with err=1 and status=0x90.
REQ-040 SHALL verify timeout: MAX_POLL=8 with status stuck at 0x00 -> 8 polls, then 0x0050 and 0x00FF, ack with err=1.
REQ-041 SHALL verify reset mid-operation: rst during low-half S_POLL -> no ack, strobes high the next cycle, pcm_rst_n=0, state S_INIT.
